// File: rtl/ps2_scan_receiver.sv
// PS/2 host-side scan-code receiver: synchronises and de-glitches the PS/2 lines,
// deframes 11-bit frames and keeps the last two valid bytes.
module ps2_scan_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] Actual,
  output logic [7:0] Anterior,
  output logic       ScanCodeType,
  output logic       FrameError,
  output logic       Busy
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s;
  logic [FW-1:0] flt_cnt;
  logic          flt_clk, flt_prev, fall;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tmo;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2Clk};
      dat_sync <= {dat_sync[0], PS2Data};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // flt_cnt counts consecutive samples that disagree with the filtered clock;
  // the FILTER_LEN-th such sample flips it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      flt_cnt  <= '0;
      flt_clk  <= 1'b1;
      flt_prev <= 1'b1;
    end else begin
      flt_prev <= flt_clk;
      if (clk_s == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_clk <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = flt_prev & ~flt_clk;
  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_ok       <= 1'b0;
      tmo          <= '0;
      Actual       <= '0;
      Anterior     <= '0;
      ScanCodeType <= 1'b0;
      FrameError   <= 1'b0;
    end else begin
      ScanCodeType <= 1'b0;
      FrameError   <= 1'b0;
      // An accepted edge takes priority over a simultaneous timeout.
      if (fall) begin
        tmo <= '0;
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s};
            state  <= STOP;
          end
          STOP: begin
            if (dat_s && par_ok) begin
              Anterior     <= Actual;
              Actual       <= shreg;
              ScanCodeType <= 1'b1;
            end else begin
              FrameError <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo <= '0;
      end else if (tmo == TW'(TIMEOUT - 1)) begin
        state      <= IDLE;
        FrameError <= 1'b1;
        shreg      <= '0;
        tmo        <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: table of frames with a strobe scoreboard, plus
// glitch, timeout and mid-frame reset sequences.
module tb_ps2_scan_receiver;

  localparam int FLEN = 8;
  localparam int TMO  = 500;
  localparam int HALF = 30;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic [7:0] Actual, Anterior;
  logic       ScanCodeType, FrameError, Busy;

  ps2_scan_receiver #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
    .Actual(Actual), .Anterior(Anterior), .ScanCodeType(ScanCodeType),
    .FrameError(FrameError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       good;
    logic [7:0] act;
    logic [7:0] ant;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic [7:0] exp_act;
    logic [7:0] exp_ant;
  } vec_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m_act = 8'h00, m_ant = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe pops the expectation pushed when its stop bit was driven.
  always @(negedge Clock) begin
    if (!Reset && (ScanCodeType || FrameError)) begin
      check("strobe_exclusive", {31'd0, ScanCodeType & FrameError}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, ScanCodeType, FrameError}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {31'd0, ScanCodeType}, {31'd0, e.good});
        check("strobe_actual", {24'd0, Actual}, {24'd0, e.act});
        check("strobe_anterior", {24'd0, Anterior}, {24'd0, e.ant});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic ps2_bit(input logic b);
    PS2Data = b;
    cyc(HALF / 2);
    PS2Clk = 1'b0;
    cyc(HALF);
    PS2Clk = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    exp_t e;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    e.good = stop & ~bad_par;
    if (e.good) begin
      m_ant = m_act;
      m_act = d;
    end
    e.act = m_act;
    e.ant = m_ant;
    sb.push_back(e);
    ps2_bit(stop);
  endtask

  vec_t vt[9];
  logic busy_seen;

  initial begin
    vt[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'h00};
    vt[1] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 8'h1C};
    vt[2] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 8'hF0};
    vt[3] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 8'hF0};
    vt[4] = '{8'h12, 1'b0, 1'b0, 8'h1C, 8'hF0};
    vt[5] = '{8'h58, 1'b0, 1'b1, 8'h58, 8'h1C};
    vt[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 8'h58};
    vt[7] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 8'h00};
    vt[8] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 8'hFF};

    cyc(3);
    check("reset_actual", {24'd0, Actual}, 32'h00);
    check("reset_anterior", {24'd0, Anterior}, 32'h00);
    check("reset_strobes", {30'd0, ScanCodeType, FrameError}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    cyc(20);

    // Frames are sent back to back with no idle PS2Clk periods in between.
    for (int i = 0; i < 9; i++) begin
      send_frame(vt[i].data, vt[i].bad_par, vt[i].stop);
      check($sformatf("vec%0d_actual", i), {24'd0, Actual}, {24'd0, vt[i].exp_act});
      check($sformatf("vec%0d_anterior", i), {24'd0, Anterior}, {24'd0, vt[i].exp_ant});
      check($sformatf("vec%0d_busy", i), {31'd0, Busy}, 32'd0);
      check($sformatf("vec%0d_sb_empty", i), sb.size(), 32'd0);
    end
    cyc(50);

    // Glitch one sample short of the filter length, with data low so a
    // detected edge would start a frame.
    busy_seen = 1'b0;
    PS2Data = 1'b0;
    PS2Clk = 1'b0;
    for (int i = 0; i < FLEN - 1; i++) begin
      cyc(1);
      busy_seen |= Busy;
    end
    PS2Clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      busy_seen |= Busy;
    end
    PS2Data = 1'b1;
    check("glitch_busy", {31'd0, busy_seen}, 32'd0);
    check("glitch_sb_empty", sb.size(), 32'd0);
    cyc(20);

    // Partial frame, then the clock stops.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    sb.push_back('{1'b0, m_act, m_ant});
    cyc(TMO - 100);
    check("timeout_not_early_busy", {31'd0, Busy}, 32'd1);
    check("timeout_not_early_sb", sb.size(), 32'd1);
    cyc(110);
    check("timeout_busy", {31'd0, Busy}, 32'd0);
    check("timeout_sb_empty", sb.size(), 32'd0);
    send_frame(8'h3A, 1'b0, 1'b1);
    check("after_timeout_actual", {24'd0, Actual}, 32'h3A);
    check("after_timeout_anterior", {24'd0, Anterior}, 32'hA5);
    cyc(20);

    // Reset in the middle of data bit 5.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    PS2Data = 1'b0;
    cyc(HALF / 2);
    PS2Clk = 1'b0;
    cyc(HALF / 2);
    check("mid_busy", {31'd0, Busy}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("rst_actual", {24'd0, Actual}, 32'h00);
    check("rst_anterior", {24'd0, Anterior}, 32'h00);
    check("rst_strobes", {30'd0, ScanCodeType, FrameError}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    cyc(5);
    PS2Clk = 1'b1;
    PS2Data = 1'b1;
    Reset = 1'b0;
    m_act = 8'h00;
    m_ant = 8'h00;
    cyc(30);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("post_rst_actual", {24'd0, Actual}, 32'h1C);
    check("post_rst_anterior", {24'd0, Anterior}, 32'h00);
    cyc(50);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 8: consecutive equal samples of synchronised PS2Clk needed before the filtered clock changes.
REQ-002 SHALL provide parameter TIMEOUT, default 5000: Clock cycles without an accepted PS2Clk falling edge before an in-progress frame is aborted.
REQ-003 SHALL have Clock  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have PS2Clk  input  1  raw PS/2 clock line, asynchronous to Clock.
REQ-006 SHALL have PS2Data  input  1  raw PS/2 data line, asynchronous to Clock.
REQ-007 SHALL have Actual  output  8  most recently received valid scan-code byte.
REQ-008 SHALL have Anterior  output  8  valid byte received before Actual.
REQ-009 SHALL have ScanCodeType  output  1  one-cycle strobe marking that Actual/Anterior were just updated.
REQ-010 SHALL have FrameError  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.
REQ-011 SHALL have Busy  output  1  high while the FSM is not in IDLE.

Function
REQ-012 SHALL pass PS2Clk and PS2Data each through a 2-flop synchroniser before any use.
REQ-013 SHALL update the filtered clock only after FILTER_LEN consecutive identical synchronised samples; the filtered clock resets to 1.
REQ-014 SHALL detect a falling edge as filtered clock 1->0, and SHALL sample synchronised PS2Data in the cycle of that detection.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on a falling edge with data 0 (start bit), SHALL go to DATA with the bit counter at 0; with data 1, SHALL stay in IDLE with no strobe.
REQ-017 DATA: SHALL shift in 8 bits LSB first, one per falling edge; after bit 7, SHALL go to PARITY.
REQ-018 PARITY: SHALL capture the parity bit; the frame has good parity when data plus parity has an odd number of ones. SHALL then go to STOP.
REQ-019 STOP, on a falling edge: if the stop bit is 1 and parity is good, SHALL load Anterior<=Actual and Actual<=byte, assert ScanCodeType for exactly the next cycle, and go to IDLE.
REQ-020 STOP, on a falling edge: otherwise SHALL leave Actual/Anterior unchanged, assert FrameError for exactly one cycle, and go to IDLE.
REQ-021 Latency: ScanCodeType SHALL rise on the Clock edge that ends the cycle in which the stop-bit falling edge is detected, and Actual/Anterior SHALL change on that same edge.
REQ-022 Timeout counter: SHALL clear on every accepted falling edge and in IDLE, and SHALL count only outside IDLE.
REQ-023 Timeout: at TIMEOUT, SHALL return to IDLE, pulse FrameError for one cycle and discard the partial byte.
REQ-024 If timeout expiry and a falling edge coincide, the edge SHALL win: it is processed and the counter clears.
REQ-025 ScanCodeType and FrameError SHALL never be high in the same cycle.
REQ-026 SHALL deliver back-to-back frames without loss, with a minimum of 0 idle PS2Clk periods between stop bit and next start bit.
REQ-027 SHALL support only host-receive; SHALL never drive PS2Clk or PS2Data.

Reset
REQ-028 SHALL, on Reset high, immediately set Actual=0x00, Anterior=0x00, ScanCodeType=0, FrameError=0, Busy=0, FSM=IDLE, counters=0, synchronisers and filtered clock=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no strobe. The first frame after release SHALL be received normally.

Verification
REQ-030 Frame 0x1C (parity 0, stop 1), then F0 (parity 1), then 1C -> three ScanCodeType pulses; final Actual=0x1C, Anterior=0xF0; FrameError never high.
REQ-031 Frame 0x1C with parity bit 1 -> one FrameError pulse, no ScanCodeType; Actual/Anterior keep their prior values.
REQ-032 Frame 0x12 with stop bit 0 -> FrameError pulse, FSM back in IDLE; a following good 0x58 -> Actual=0x58.
REQ-033 Start bit plus 4 data bits, then PS2Clk held high for TIMEOUT+10 cycles -> one FrameError pulse at TIMEOUT; Busy=0; the next good frame is received.
REQ-034 PS2Clk glitch low for FILTER_LEN-1 cycles while IDLE -> no edge detected, Busy stays 0, no strobes.
REQ-035 Reset pulsed during DATA bit 5 -> all outputs 0 immediately, no strobe; the next good frame 0x1C -> Actual=0x1C, Anterior=0x00.
